// File: rtl/rvmem_pkg.sv
// rvmem_pkg: shared types and helpers for the rvmem BRAM slave.
//   wstate_t       - write-channel FSM states
//   BYTES_PER_WORD, IDX_WIDTH, OFF_WIDTH - geometry of the default 32-bit x 4096 build
//   in_range()     - byte-address window test (addr in [base, base+span))
package rvmem_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    localparam int DFLT_DATA_WIDTH  = 32;
    localparam int DFLT_DEPTH_WORDS = 4096;
    localparam int BYTES_PER_WORD   = DFLT_DATA_WIDTH / 8;
    localparam int IDX_WIDTH        = $clog2(DFLT_DEPTH_WORDS);
    localparam int OFF_WIDTH        = $clog2(BYTES_PER_WORD);

    // Arguments are zero-extended byte addresses; span is the window size in bytes.
    // The subtraction only happens once addr >= base, so it never wraps.
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/rvmem_rd_pipe.sv
// rvmem_rd_pipe: read-return timing for the BRAM slave.
//   LAT-deep valid shift register plus a one-entry holding register, so read data
//   appears exactly LAT cycles after acceptance and stays put until the core takes it.
// Ports:
//   clock, reset   - clock, async active-low reset
//   acc            - read address accepted this cycle (BRAM is being read now)
//   din [PW]       - BRAM output payload, valid the cycle after acc
//   rden           - consumer ready
//   busy           - a read is in flight or held (blocks new acceptance)
//   vld, dout [PW] - read data valid / payload (payload is 0 when vld is low)
module rvmem_rd_pipe #(
    parameter int LAT = 1,
    parameter int PW  = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          acc,
    input  logic [PW-1:0] din,
    input  logic          rden,
    output logic          busy,
    output logic          vld,
    output logic [PW-1:0] dout
);

    logic [LAT:1]  vld_pipe;
    logic          hold_vld;
    logic [PW-1:0] hold_dat;
    logic [PW-1:0] tail;

    // din is already one register behind acc, so only LAT-1 more data stages are needed.
    generate
        if (LAT == 1) begin : g_nodly
            assign tail = din;
        end else begin : g_dly
            logic [LAT-2:0][PW-1:0] dly;
            always_ff @(posedge clock) begin
                dly[0] <= din;
                for (int i = 1; i <= LAT - 2; i++) dly[i] <= dly[i-1];
            end
            assign tail = dly[LAT-2];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            hold_vld <= 1'b0;
            hold_dat <= '0;
        end else begin
            vld_pipe[1] <= acc;
            for (int i = 2; i <= LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
            // Park the last stage if the core is not ready; release on rden.
            if (vld_pipe[LAT] && !rden) begin
                hold_vld <= 1'b1;
                hold_dat <= tail;
            end else if (hold_vld && rden) begin
                hold_vld <= 1'b0;
            end
        end
    end

    assign vld  = hold_vld | vld_pipe[LAT];
    assign busy = (|vld_pipe) | hold_vld;
    assign dout = hold_vld ? hold_dat : (vld_pipe[LAT] ? tail : '0);

endmodule

// File: rtl/rvmem_bram_slave.sv
// rvmem_bram_slave: byte-enable BRAM word memory on the core's external memory port.
//   Split write address/data channels with a one-cycle wbvld completion pulse, and a
//   read channel (one outstanding read) with READ_LAT latency and rden back-pressure.
//   Out-of-range writes are dropped, out-of-range reads return 0; read-first on collision.
// Optional: define RVMEM_ERR_RESP_EN to add werr/rerr (out of range or misaligned);
//   misaligned accesses are then dropped / read as 0. Without it the low offset bits
//   are simply ignored.
// Ports:
//   clock, reset                  - clock, async active-low reset
//   waen/waddr/wardy              - write address channel
//   wden/wdata/wmask/wdrdy        - write data channel (byte enables)
//   wbvld [werr]                  - write complete pulse
//   raen/raddr/rardy              - read address channel
//   rden/rdata/rdrdy [rerr]       - read data channel
module rvmem_bram_slave
    import rvmem_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h8000_0000),
    parameter int                    READ_LAT    = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    waen,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    output logic                    wardy,
    input  logic                    wden,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wmask,
    output logic                    wdrdy,
    output logic                    wbvld,
`ifdef RVMEM_ERR_RESP_EN
    output logic                    werr,
`endif
    input  logic                    raen,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic                    rardy,
    input  logic                    rden,
    output logic [DATA_WIDTH-1:0]   rdata,
`ifdef RVMEM_ERR_RESP_EN
    output logic                    rerr,
`endif
    output logic                    rdrdy
);

    localparam int                    BPW      = DATA_WIDTH / 8;
    localparam int                    OFF_W    = $clog2(BPW);
    localparam int                    IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [63:0]           SPAN     = 64'(DEPTH_WORDS) * 64'(BPW);
    localparam logic [63:0]           BASE64   = 64'(BASE_ADDR);
`ifdef RVMEM_ERR_RESP_EN
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BPW - 1);
    localparam int                    PW       = DATA_WIDTH + 1;
`else
    localparam int                    PW       = DATA_WIDTH;
`endif

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> OFF_W);
    endfunction

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
`ifdef RVMEM_ERR_RESP_EN
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return in_range(64'(a), BASE64, SPAN) && ((off & OFF_MASK) == '0);
`else
        return in_range(64'(a), BASE64, SPAN);
`endif
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // ---------------- write channel ----------------
    wstate_t               wstate;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_fire;

    // In W_IDLE the data can only be the same-cycle partner of waen, so use the live address.
    assign wr_addr = (wstate == W_IDLE) ? waddr : waddr_q;
    assign wardy   = reset && (wstate == W_IDLE);
    assign wdrdy   = reset && ((wstate == W_DATA) || ((wstate == W_IDLE) && waen));
    assign wr_fire = wden && wdrdy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wstate  <= W_IDLE;
            waddr_q <= '0;
            wbvld   <= 1'b0;
`ifdef RVMEM_ERR_RESP_EN
            werr    <= 1'b0;
`endif
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (waen) begin
                        waddr_q <= waddr;
                        wstate  <= wden ? W_RESP : W_DATA;
                        wbvld   <= wden;
`ifdef RVMEM_ERR_RESP_EN
                        werr    <= wden && !addr_ok(waddr);
`endif
                    end
                end
                W_DATA: begin
                    if (wden) begin
                        wstate <= W_RESP;
                        wbvld  <= 1'b1;
`ifdef RVMEM_ERR_RESP_EN
                        werr   <= !addr_ok(waddr_q);
`endif
                    end
                end
                W_RESP: begin
                    wstate <= W_IDLE;
                    wbvld  <= 1'b0;
`ifdef RVMEM_ERR_RESP_EN
                    werr   <= 1'b0;
`endif
                end
                default: begin
                    wstate <= W_IDLE;
                    wbvld  <= 1'b0;
`ifdef RVMEM_ERR_RESP_EN
                    werr   <= 1'b0;
`endif
                end
            endcase
        end
    end

    // ---------------- read channel ----------------
    logic                  rd_acc;
    logic                  rd_busy;
    logic                  rd_ok_q;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [PW-1:0]         rd_payload;
    logic [PW-1:0]         rd_out;

    assign rardy  = reset && !rd_busy;
    assign rd_acc = raen && rardy;

    // Memory port: nonblocking read and write in one block give read-first on collision.
    always_ff @(posedge clock) begin
        if (rd_acc) rd_word <= mem[word_idx(raddr)];
        if (wr_fire && addr_ok(wr_addr)) begin
            for (int b = 0; b < BPW; b++) begin
                if (wmask[b]) mem[word_idx(wr_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      rd_ok_q <= 1'b0;
        else if (rd_acc) rd_ok_q <= addr_ok(raddr);
    end

`ifdef RVMEM_ERR_RESP_EN
    assign rd_payload = {!rd_ok_q, (rd_ok_q ? rd_word : '0)};
`else
    assign rd_payload = rd_ok_q ? rd_word : '0;
`endif

    rvmem_rd_pipe #(
        .LAT (READ_LAT),
        .PW  (PW)
    ) u_rd_pipe (
        .clock (clock),
        .reset (reset),
        .acc   (rd_acc),
        .din   (rd_payload),
        .rden  (rden),
        .busy  (rd_busy),
        .vld   (rdrdy),
        .dout  (rd_out)
    );

`ifdef RVMEM_ERR_RESP_EN
    assign {rerr, rdata} = rd_out;
`else
    assign rdata = rd_out;
`endif

endmodule

// File: tb/tb_rvmem_bram_slave.sv
// Scoreboard bench for rvmem_bram_slave (READ_LAT=3). Stimulus pushes expected
// write responses / read data into queues; a negedge monitor pops and compares.
module tb_rvmem_bram_slave;

    localparam int LAT = 3;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rexp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        waen = 1'b0, wden = 1'b0, raen = 1'b0, rden = 1'b1;
    logic [31:0] waddr = '0, wdata = '0, raddr = '0;
    logic [3:0]  wmask = '0;
    logic        wardy, wdrdy, wbvld, rardy, rdrdy;
    logic [31:0] rdata;
`ifdef RVMEM_ERR_RESP_EN
    logic        werr, rerr;
`endif

    int    checks = 0;
    int    errors = 0;
    logic  wq[$];
    rexp_t rq[$];
    rexp_t re;
    logic  we;

    always #5 clock = ~clock;

    rvmem_bram_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (4096),
        .BASE_ADDR   (32'h8000_0000),
        .READ_LAT    (LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .waen  (waen),
        .waddr (waddr),
        .wardy (wardy),
        .wden  (wden),
        .wdata (wdata),
        .wmask (wmask),
        .wdrdy (wdrdy),
        .wbvld (wbvld),
`ifdef RVMEM_ERR_RESP_EN
        .werr  (werr),
`endif
        .raen  (raen),
        .raddr (raddr),
        .rardy (rardy),
        .rden  (rden),
        .rdata (rdata),
`ifdef RVMEM_ERR_RESP_EN
        .rerr  (rerr),
`endif
        .rdrdy (rdrdy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the queue heads.
    always @(negedge clock) begin
        if (reset) begin
            if (wbvld) begin
                if (wq.size() == 0) fail("wbvld_unexpected");
                else begin
                    we = wq.pop_front();
`ifdef RVMEM_ERR_RESP_EN
                    chk("werr", 32'(werr), 32'(we));
`endif
                end
            end
            if (rdrdy) begin
                if (rq.size() == 0) fail("rdrdy_unexpected");
                else begin
                    re = rq[0];
                    chk("rdata", rdata, re.data);
`ifdef RVMEM_ERR_RESP_EN
                    chk("rerr", 32'(rerr), 32'(re.err));
`endif
                    if (rden) rq.pop_front();
                end
            end
        end
    end

    task automatic wait_wardy();
        int n = 0;
        while (!wardy && n < 50) begin tick(); n++; end
        if (!wardy) fail("wardy_timeout");
    endtask

    task automatic wait_rardy();
        int n = 0;
        while (!rardy && n < 50) begin tick(); n++; end
        if (!rardy) fail("rardy_timeout");
    endtask

    // Called in the cycle after acceptance; returns the observed latency.
    task automatic wait_rd_done(output int lat);
        int n = 1;
        int m = 0;
        while (!rdrdy && n < 20) begin tick(); n++; end
        if (!rdrdy) fail("rdrdy_timeout");
        lat = n;
        while (rdrdy && m < 20) begin tick(); m++; end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      input logic e);
        wait_wardy();
        waen = 1'b1; wden = 1'b1; waddr = a; wdata = d; wmask = m;
        wq.push_back(e);
        tick();
        waen = 1'b0; wden = 1'b0;
        chk("wbvld_next_cycle", 32'(wbvld), 32'd1);
        tick();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic e);
        int lat;
        wait_rardy();
        raen = 1'b1; raddr = a;
        rq.push_back('{data: d, err: e});
        tick();
        raen = 1'b0;
        wait_rd_done(lat);
        chk("rd_latency", 32'(lat), 32'(LAT));
        chk("rardy_after_take", 32'(rardy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        int lat;

        // reset state
        #3;
        chk("rst_wardy", 32'(wardy), 0);
        chk("rst_wdrdy", 32'(wdrdy), 0);
        chk("rst_wbvld", 32'(wbvld), 0);
        chk("rst_rardy", 32'(rardy), 0);
        chk("rst_rdrdy", 32'(rdrdy), 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        tick();
        chk("idle_wardy", 32'(wardy), 1);
        chk("idle_rardy", 32'(rardy), 1);

        // aligned write then read
        wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        rd(32'h8000_0010, 32'hDEAD_BEEF, 1'b0);

        // data before address is refused
        wden = 1'b1; wdata = 32'hFFFF_FFFF; wmask = 4'hF;
        chk("wdrdy_no_addr", 32'(wdrdy), 0);
        tick();
        wden = 1'b0;
        chk("no_wbvld_no_addr", 32'(wbvld), 0);

        // split write over a zeroed word
        wr(32'h8000_0020, 32'h0, 4'hF, 1'b0);
        wait_wardy();
        waen = 1'b1; waddr = 32'h8000_0020;
        tick();
        waen = 1'b0; waddr = 32'h0;
        chk("split_wardy_c1", 32'(wardy), 0);
        chk("split_wdrdy_c1", 32'(wdrdy), 1);
        tick();
        chk("split_wardy_c2", 32'(wardy), 0);
        tick();
        wden = 1'b1; wdata = 32'h1122_3344; wmask = 4'h5;
        wq.push_back(1'b0);
        chk("split_wardy_c3", 32'(wardy), 0);
        tick();
        wden = 1'b0;
        chk("split_wbvld_c4", 32'(wbvld), 1);
        tick();
        rd(32'h8000_0020, 32'h0022_0044, 1'b0);

        // back-pressure: rdrdy/rdata held while rden low
        rden = 1'b0;
        wait_rardy();
        raen = 1'b1; raddr = 32'h8000_0010;
        rq.push_back('{data: 32'hDEAD_BEEF, err: 1'b0});
        tick();
        raen = 1'b0;
        lat = 1;
        while (!rdrdy && lat < 20) begin tick(); lat++; end
        chk("bp_latency", 32'(lat), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            chk("bp_rdrdy_held", 32'(rdrdy), 1);
            chk("bp_rardy_low", 32'(rardy), 0);
            tick();
        end
        rden = 1'b1;
        chk("bp_rardy_take_cycle", 32'(rardy), 0);
        tick();
        chk("bp_rdrdy_drop", 32'(rdrdy), 0);
        chk("bp_rardy_back", 32'(rardy), 1);

        // same-cycle read/write collision: read-first
        wr(32'h8000_0040, 32'hAAAA_AAAA, 4'hF, 1'b0);
        wait_wardy();
        wait_rardy();
        waen = 1'b1; wden = 1'b1; waddr = 32'h8000_0040; wdata = 32'h5555_5555; wmask = 4'hF;
        raen = 1'b1; raddr = 32'h8000_0040;
        wq.push_back(1'b0);
        rq.push_back('{data: 32'hAAAA_AAAA, err: 1'b0});
        tick();
        waen = 1'b0; wden = 1'b0; raen = 1'b0;
        chk("coll_wbvld", 32'(wbvld), 1);
        wait_rd_done(lat);
        chk("coll_latency", 32'(lat), 32'(LAT));
        rd(32'h8000_0040, 32'h5555_5555, 1'b0);

        // range boundaries
        wr(32'h8000_3FFC, 32'h1234_5678, 4'hF, 1'b0);
        wr(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 1'b0);
        wr(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 1'b1);
        rd(32'h8000_3FFC, 32'h1234_5678, 1'b0);
        rd(32'h8000_4000, 32'h0, 1'b1);
`ifdef RVMEM_ERR_RESP_EN
        rd(32'h8000_0002, 32'h0, 1'b1);
        wr(32'h8000_0001, 32'hFFFF_FFFF, 4'hF, 1'b1);
        rd(32'h8000_0000, 32'hCAFE_F00D, 1'b0);
`else
        rd(32'h8000_0002, 32'hCAFE_F00D, 1'b0);
`endif

        // reset with a write waiting for data and a read in flight
        wr(32'h8000_0030, 32'h0BAD_CAFE, 4'hF, 1'b0);
        wait_wardy();
        waen = 1'b1; waddr = 32'h8000_0030;
        tick();
        waen = 1'b0;
        chk("mid_wdrdy", 32'(wdrdy), 1);
        wait_rardy();
        raen = 1'b1; raddr = 32'h8000_0010;
        rq.push_back('{data: 32'hDEAD_BEEF, err: 1'b0});
        tick();
        raen = 1'b0;
        #2;
        reset = 1'b0;
        rq.delete();
        #1;
        chk("arst_wardy", 32'(wardy), 0);
        chk("arst_wdrdy", 32'(wdrdy), 0);
        chk("arst_wbvld", 32'(wbvld), 0);
        chk("arst_rardy", 32'(rardy), 0);
        chk("arst_rdrdy", 32'(rdrdy), 0);
        chk("arst_rdata", rdata, 0);
        wden = 1'b1; wdata = 32'hFFFF_FFFF; wmask = 4'hF;
        tick();
        tick();
        wden = 1'b0;
        reset = 1'b1;
        #3;
        chk("rel_wardy", 32'(wardy), 1);
        chk("rel_rardy", 32'(rardy), 1);
        tick();
        chk("rel_no_wbvld", 32'(wbvld), 0);
        chk("rel_no_rdrdy", 32'(rdrdy), 0);
        rd(32'h8000_0030, 32'h0BAD_CAFE, 1'b0);

        tick();
        tick();
        chk("wq_drained", 32'(wq.size()), 0);
        chk("rq_drained", 32'(rq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvmem_bram_slave.md
Name: rvmem_bram_slave

Overview:
- Parametrised successor to the fixed external-memory slave on the core's io_ext_mem port.
- Block-RAM backed word memory with split write-address/write-data channels, a write-response pulse, and a read channel with configurable latency and back-pressure.
- Sits between the rv32i core's external memory interface and on-chip BRAM.
- Adds capabilities the current slave lacks: configurable depth, width and base address, address-range checking, and read data held under back-pressure.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- DEPTH_WORDS, 4096, memory depth in words; must be a power of two.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- READ_LAT, 1, cycles from read-address acceptance to rdrdy; legal range 1..4.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- waen  in  1  write address valid.
- waddr  in  ADDR_WIDTH  write byte address.
- wardy  out  1  write address accepted.
- wden  in  1  write data valid.
- wdata  in  DATA_WIDTH  write data.
- wmask  in  DATA_WIDTH/8  byte enables.
- wdrdy  out  1  write data accepted.
- wbvld  out  1  write-complete pulse.
- raen  in  1  read address valid.
- raddr  in  ADDR_WIDTH  read byte address.
- rardy  out  1  read address accepted.
- rden  in  1  core ready to take read data.
- rdata  out  DATA_WIDTH  read data.
- rdrdy  out  1  read data valid.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; write FSM to W_IDLE; read pipeline emptied; memory contents not cleared.
- Handshake rule: a transfer occurs on a rising clock edge when both valid and ready are high.
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored.
- In range: BASE_ADDR <= addr < BASE_ADDR + DEPTH_WORDS*DATA_WIDTH/8. Arithmetic is unsigned ADDR_WIDTH.
- Write FSM states:
  - W_IDLE: wardy=1. On waen, latch the address; if wden is also high that cycle, accept data too (wdrdy=1 combinationally) and go to W_RESP; otherwise go to W_DATA.
  - W_DATA: wardy=0, wdrdy=1. On wden, commit the write and go to W_RESP.
  - W_RESP: wbvld=1 for exactly one cycle, then return to W_IDLE.
  - Data arriving before its address is not accepted: wdrdy=0 in W_IDLE unless waen is high.
- Write commit: bytes with wmask bit set are written in the acceptance cycle. A zero mask is a legal no-op that still pulses wbvld. Out-of-range writes are dropped and still pulse wbvld.
- Read channel:
  - rardy = 1 when no read is in flight and no held data exists. At most one outstanding read.
  - BRAM is read in the acceptance cycle. rdrdy rises exactly READ_LAT cycles after acceptance.
  - Read data and rdrdy are held stable until rden is high. rardy returns high the cycle after rdrdy&&rden.
  - Out-of-range reads return 0.
- Simultaneous read and write to the same word in the same cycle: read-first (old data returned).
- Read and write channels are otherwise independent and may proceed concurrently.
- Reset mid-transaction: in-flight write abandoned (no commit if data was not yet accepted, no wbvld); in-flight read discarded.

Optional Feature:
- Macro RVMEM_ERR_RESP_EN.
- When defined:
  - Adds output ports werr (1) and rerr (1).
  - werr is valid with wbvld; rerr is valid with rdrdy.
  - Each is 1 when the transaction's address was out of range or misaligned (low byte-offset bits nonzero).
  - Misaligned writes are dropped. Misaligned reads return 0.
- When undefined: ports absent; misalignment ignored by truncating the low bits; range behaviour as above.

Decomposition:
- Package rvmem_pkg:
  - write FSM state enum (W_IDLE, W_DATA, W_RESP);
  - localparam helpers for BYTES_PER_WORD, IDX_WIDTH = $clog2(DEPTH_WORDS), OFF_WIDTH;
  - function in_range(addr, base, depth).
- Sub-module rvmem_rd_pipe: READ_LAT-deep valid/data shift stage plus a one-entry holding register producing rdrdy/rdata under rden back-pressure.
- The memory array stays in the top as an inferred byte-enable BRAM.

Test Plan:
- Aligned write then read: write 0x8000_0010 ← 0xDEADBEEF with mask 0xF (waen and wden same cycle) → wbvld on the 2nd cycle; read 0x8000_0010 → rdata=0xDEADBEEF after READ_LAT.
- Split write: waen with 0x8000_0020 at cycle 0, wden with 0x11223344 and mask 0x5 at cycle 3 → wardy=0 during cycles 1–3, wbvld at cycle 4; read-back = 0x00220044 over prior zeros.
- Read back-pressure, READ_LAT=3: hold rden=0 for 5 cycles → rdrdy high from cycle 3 with stable rdata; rardy=0 until the cycle after rden is asserted.
- Same-cycle collision: word 0x8000_0040 holds 0xAAAA_AAAA; read and write 0x5555_5555 to it in the same cycle → read returns 0xAAAA_AAAA; next read returns 0x5555_5555.
- Out of range: write to 0x7FFF_FFFC → wbvld pulses, memory unchanged; read of BASE_ADDR + DEPTH_WORDS*4 → 0. With RVMEM_ERR_RESP_EN defined, werr=1 and rerr=1; a misaligned read at 0x8000_0002 gives rerr=1 and rdata=0.
- Reset asserted in W_DATA and with a read in flight → all outputs 0 asynchronously; after release, wardy=1 and rardy=1; no wbvld; memory unchanged.
